// File: rtl/conv_sched_pkg.sv
// Shared constants for the convolution job scheduler:
// FSM state codes, completion status codes and job record layout.
package conv_sched_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LAUNCH = 3'd1;
    localparam logic [2:0] RUN    = 3'd2;
    localparam logic [2:0] CLEAR  = 3'd3;
    localparam logic [2:0] REPORT = 3'd4;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK      = 2'b00;
    localparam status_t ST_TIMEOUT = 2'b01;
    localparam status_t ST_ABORT   = 2'b10;

    // Record layout, LSB first: out_base, w_base, in_base, id.
    function automatic int rec_w(input int idw, input int aw);
        return idw + 3 * aw;
    endfunction

    function automatic int off_out(input int aw);
        return 0 * aw;
    endfunction

    function automatic int off_w(input int aw);
        return 1 * aw;
    endfunction

    function automatic int off_in(input int aw);
        return 2 * aw;
    endfunction

    function automatic int off_id(input int aw);
        return 3 * aw;
    endfunction

endpackage

// File: rtl/conv_job_fifo.sv
// Synchronous job FIFO with occupancy count.
// DEPTH must be a power of two; pointers wrap naturally.
module conv_job_fifo
    import conv_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CAP);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv_job_scheduler.sv
// Queues conv jobs and runs them one at a time on a single conv engine.
// Define CONV_SCHED_PERF_EN to add the job_cycles/jobs_done counters.
module conv_job_scheduler
    import conv_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDRW   = 32,
    parameter int IDW     = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [IDW-1:0]   job_id,
    input  logic [ADDRW-1:0] job_in_base,
    input  logic [ADDRW-1:0] job_w_base,
    input  logic [ADDRW-1:0] job_out_base,
    input  logic             abort,
    output logic             eng_start,
    output logic             eng_rst,
    output logic [ADDRW-1:0] eng_in_base,
    output logic [ADDRW-1:0] eng_w_base,
    output logic [ADDRW-1:0] eng_out_base,
    input  logic             eng_finish,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [IDW-1:0]   done_id,
    output logic [1:0]       done_status
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]      job_cycles,
    output logic [15:0]      jobs_done
`endif
);

    localparam int RW = rec_w(IDW, ADDRW);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    logic [2:0]              state;
    logic [31:0]             timer;
    logic [IDW-1:0]          cur_id;
    logic [RW-1:0]           fifo_din;
    logic [RW-1:0]           fifo_dout;
    logic [$clog2(DEPTH):0]  fifo_count_unused;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    timeout_hit;
    logic                    run_exit;
    status_t                 run_status;

    assign fifo_din = {job_id, job_in_base, job_w_base, job_out_base};
    assign pop      = (state == IDLE) && !fifo_empty;

    conv_job_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (job_valid),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count_unused),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign job_ready  = !fifo_full;
    assign eng_start  = (state == LAUNCH);
    assign eng_rst    = !rst || (state == CLEAR);
    assign busy       = (state != IDLE);
    assign done_valid = (state == REPORT);

    assign timeout_hit = (TIMEOUT != 0) && (timer == TO_LAST);
    assign run_exit    = eng_finish || abort || timeout_hit;

    // Finish wins over abort, abort wins over timeout.
    always_comb begin
        run_status = ST_TIMEOUT;
        if (eng_finish) begin
            run_status = ST_OK;
        end else if (abort) begin
            run_status = ST_ABORT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            timer        <= '0;
            cur_id       <= '0;
            eng_in_base  <= '0;
            eng_w_base   <= '0;
            eng_out_base <= '0;
            done_id      <= '0;
            done_status  <= ST_OK;
`ifdef CONV_SCHED_PERF_EN
            job_cycles   <= '0;
            jobs_done    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cur_id       <= fifo_dout[off_id(ADDRW) +: IDW];
                        eng_in_base  <= fifo_dout[off_in(ADDRW) +: ADDRW];
                        eng_w_base   <= fifo_dout[off_w(ADDRW) +: ADDRW];
                        eng_out_base <= fifo_dout[off_out(ADDRW) +: ADDRW];
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= RUN;
                end
                RUN: begin
                    timer <= timer + 32'd1;
                    if (run_exit) begin
                        done_id     <= cur_id;
                        done_status <= run_status;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
`ifdef CONV_SCHED_PERF_EN
                    job_cycles <= timer;
`endif
                    state <= REPORT;
                end
                REPORT: begin
                    if (done_ready) begin
`ifdef CONV_SCHED_PERF_EN
                        if (jobs_done != 16'hFFFF) begin
                            jobs_done <= jobs_done + 16'd1;
                        end
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Directed bench for conv_job_scheduler (DEPTH=4, TIMEOUT=100)
// with a hand-driven engine model.
module tb_conv_job_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [3:0]  job_id;
    logic [31:0] job_in_base;
    logic [31:0] job_w_base;
    logic [31:0] job_out_base;
    logic        abort;
    logic        eng_start;
    logic        eng_rst;
    logic [31:0] eng_in_base;
    logic [31:0] eng_w_base;
    logic [31:0] eng_out_base;
    logic        eng_finish;
    logic        busy;
    logic        done_valid;
    logic        done_ready;
    logic [3:0]  done_id;
    logic [1:0]  done_status;

    int checks = 0;
    int failures = 0;

    conv_job_scheduler #(
        .DEPTH   (4),
        .ADDRW   (32),
        .IDW     (4),
        .TIMEOUT (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_id       (job_id),
        .job_in_base  (job_in_base),
        .job_w_base   (job_w_base),
        .job_out_base (job_out_base),
        .abort        (abort),
        .eng_start    (eng_start),
        .eng_rst      (eng_rst),
        .eng_in_base  (eng_in_base),
        .eng_w_base   (eng_w_base),
        .eng_out_base (eng_out_base),
        .eng_finish   (eng_finish),
        .busy         (busy),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .done_id      (done_id),
        .done_status  (done_status)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bi(input logic [3:0] id);
        return {24'h0, id, 4'h0};
    endfunction

    function automatic logic [31:0] bw(input logic [3:0] id);
        return 32'h0000_1000 + {20'h0, id, 8'h0};
    endfunction

    function automatic logic [31:0] bo(input logic [3:0] id);
        return 32'h8000_0000 | {28'h0, id};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] id);
        job_valid    = 1'b1;
        job_id       = id;
        job_in_base  = bi(id);
        job_w_base   = bw(id);
        job_out_base = bo(id);
        chk("push_ready", job_ready, 1);
        step();
        job_valid = 1'b0;
    endtask

    task automatic wait_start(input int max);
        int n = 0;
        while (eng_start !== 1'b1 && n < max) begin
            step();
            n++;
        end
        chk("start_seen", eng_start, 1);
    endtask

    // Called in the LAUNCH cycle s; the engine reacts in cycle s+lat.
    task automatic finish_job(input logic [3:0] id, input logic [31:0] xi,
                              input logic [31:0] xw, input logic [31:0] xo,
                              input int lat, input logic fin,
                              input logic ab, input logic [1:0] st,
                              input int hold);
        chk("launch_start", eng_start, 1);
        chk("launch_in", eng_in_base, xi);
        chk("launch_w", eng_w_base, xw);
        chk("launch_out", eng_out_base, xo);
        step();
        job_valid = 1'b0;
        chk("start_pulse", eng_start, 0);
        repeat (lat - 1) step();
        chk("still_run", eng_rst, 0);
        chk("still_busy", busy, 1);
        eng_finish = fin;
        abort      = ab;
        step();
        chk("clear_rst", eng_rst, 1);
        chk("clear_nodone", done_valid, 0);
        eng_finish = 1'b0;
        abort      = 1'b0;
        step();
        chk("rst_once", eng_rst, 0);
        chk("done_valid", done_valid, 1);
        chk("done_id", done_id, id);
        chk("done_status", done_status, st);
        chk("hold_in", eng_in_base, xi);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", done_valid, 1);
            chk("hold_id", done_id, id);
            chk("hold_status", done_status, st);
        end
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        chk("done_drop", done_valid, 0);
    endtask

    initial begin
        int seen;
        rst          = 1'b0;
        job_valid    = 1'b0;
        job_id       = '0;
        job_in_base  = '0;
        job_w_base   = '0;
        job_out_base = '0;
        abort        = 1'b0;
        eng_finish   = 1'b0;
        done_ready   = 1'b0;
        #2;
        chk("rst_eng_rst", eng_rst, 1);
        chk("rst_start", eng_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_valid, 0);
        chk("rst_id", done_id, 0);
        chk("rst_in", eng_in_base, 0);
        chk("rst_ready", job_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rel_eng_rst", eng_rst, 0);

        // Single job, exact latency.
        job_valid    = 1'b1;
        job_id       = 4'd3;
        job_in_base  = 32'd0;
        job_w_base   = 32'd3136;
        job_out_base = 32'd4096;
        chk("t1_ready", job_ready, 1);
        step();
        job_valid = 1'b0;
        chk("t1_c1_start", eng_start, 0);
        chk("t1_c1_busy", busy, 0);
        step();
        chk("t1_c2_busy", busy, 1);
        finish_job(4'd3, 32'd0, 32'd3136, 32'd4096, 50, 1'b1, 1'b0,
                   2'b00, 2);
        chk("t1_idle", busy, 0);
        chk("t1_keep_w", eng_w_base, 3136);
        chk("t1_keep_out", eng_out_base, 4096);

        // Back-to-back jobs, FIFO order.
        push(4'd1);
        push(4'd2);
        wait_start(10);
        finish_job(4'd1, bi(1), bw(1), bo(1), 20, 1'b1, 1'b0, 2'b00, 0);
        wait_start(10);
        finish_job(4'd2, bi(2), bw(2), bo(2), 20, 1'b1, 1'b0, 2'b00, 0);
        chk("t2_idle", busy, 0);

        // Timeout after exactly 100 RUN cycles, then a normal job.
        push(4'd5);
        wait_start(10);
        finish_job(4'd5, bi(5), bw(5), bo(5), 100, 1'b0, 1'b0, 2'b01, 0);
        push(4'd6);
        wait_start(10);
        finish_job(4'd6, bi(6), bw(6), bo(6), 20, 1'b1, 1'b0, 2'b00, 0);

        // Full FIFO: five accepts, sixth held until a slot frees.
        push(4'd8);
        push(4'd9);
        push(4'd10);
        push(4'd11);
        push(4'd12);
        chk("t4_run_in", eng_in_base, bi(8));
        job_valid    = 1'b1;
        job_id       = 4'd13;
        job_in_base  = bi(13);
        job_w_base   = bw(13);
        job_out_base = bo(13);
        chk("t4_full", job_ready, 0);
        step();
        step();
        chk("t4_full_hold", job_ready, 0);
        eng_finish = 1'b1;
        step();
        eng_finish = 1'b0;
        chk("t4_clear", eng_rst, 1);
        chk("t4_full_clr", job_ready, 0);
        step();
        chk("t4_done_id", done_id, 8);
        chk("t4_done_st", done_status, 0);
        chk("t4_full_rep", job_ready, 0);
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        chk("t4_full_pop", job_ready, 0);
        step();
        chk("t4_ready_back", job_ready, 1);
        finish_job(4'd9, bi(9), bw(9), bo(9), 5, 1'b1, 1'b0, 2'b00, 0);
        for (int k = 10; k <= 13; k++) begin
            wait_start(10);
            finish_job(4'(k), bi(4'(k)), bw(4'(k)), bo(4'(k)), 3,
                       1'b1, 1'b0, 2'b00, 0);
        end
        chk("t4_drained", busy, 0);

        // Finish beats abort; abort alone at RUN cycle 10.
        push(4'd2);
        wait_start(10);
        finish_job(4'd2, bi(2), bw(2), bo(2), 5, 1'b1, 1'b1, 2'b00, 0);
        push(4'd4);
        wait_start(10);
        finish_job(4'd4, bi(4), bw(4), bo(4), 10, 1'b0, 1'b1, 2'b10, 0);
        abort      = 1'b1;
        eng_finish = 1'b1;
        step();
        step();
        step();
        chk("t5_abort_idle", busy, 0);
        chk("t5_abort_done", done_valid, 0);
        abort      = 1'b0;
        eng_finish = 1'b0;
        step();

        // Reset mid-RUN with a job still queued.
        push(4'd7);
        push(4'd8);
        wait_start(10);
        repeat (30) step();
        chk("t6_pre_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("t6_eng_rst", eng_rst, 1);
        chk("t6_busy", busy, 0);
        chk("t6_start", eng_start, 0);
        chk("t6_done", done_valid, 0);
        chk("t6_status", done_status, 0);
        chk("t6_in", eng_in_base, 0);
        chk("t6_w", eng_w_base, 0);
        chk("t6_out", eng_out_base, 0);
        chk("t6_ready", job_ready, 1);
        step();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (busy || done_valid || eng_start) seen++;
        end
        chk("t6_silent", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_job_scheduler.md
Name: conv_job_scheduler

Overview:
Queues convolution jobs and runs them one at a time on a single conv engine (the 3x3 line-buffer conv core). Each job carries an input base, a weight/bias base and an output base. For each job the block:
- drives the engine's base-address configuration;
- pulses the engine's start;
- supervises the run with a timeout and an abort;
- resets the engine after each job, because the engine's finish is sticky;
- posts a completion record to the host.

Parameters:
DEPTH, 4, job FIFO entries (power of 2, at least 2)
ADDRW, 32, address width of the base fields
IDW, 4, job identifier width
TIMEOUT, 65535, maximum cycles in RUN before forced termination; 0 disables the timeout

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-low
job_valid  in  1  host offers a job
job_ready  out  1  FIFO can accept a job
job_id  in  IDW  job tag
job_in_base  in  ADDRW  pixel base address
job_w_base  in  ADDRW  weight/bias base address
job_out_base  in  ADDRW  output base address
abort  in  1  level; terminates the running job
eng_start  out  1  one-cycle start pulse to the engine
eng_rst  out  1  active-high synchronous reset to the engine
eng_in_base  out  ADDRW  configuration, held stable for the whole job
eng_w_base  out  ADDRW  configuration, held stable for the whole job
eng_out_base  out  ADDRW  configuration, held stable for the whole job
eng_finish  in  1  engine done (sticky until eng_rst)
busy  out  1  state is not IDLE
done_valid  out  1  completion record valid
done_ready  in  1  host accepts the completion record
done_id  out  IDW  tag of the completed job
done_status  out  2  00 OK, 01 TIMEOUT, 10 ABORT

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst=0):
  - FIFO emptied; state returns to IDLE.
  - eng_start=0, done_valid=0, done_id=0, done_status=0, busy=0.
  - eng_*_base outputs = 0; timer = 0.
  - eng_rst is forced to 1 combinationally while rst=0, so the engine is also reset.
  - Reset taken mid-RUN abandons the job silently: no completion record is posted.
- Job FIFO:
  - job_ready = (count < DEPTH). It does not depend on a pop in the same cycle.
  - A push occurs when job_valid & job_ready; a push while full is impossible, and the job stays with the host.
  - A simultaneous push and pop is legal.
  - Jobs are served in strict FIFO order.
- FSM:
  - IDLE: if the FIFO is not empty, pop the head and latch id and bases into eng_*_base; go to LAUNCH.
  - LAUNCH: eng_start=1 for exactly this cycle; timer cleared; go to RUN.
  - RUN: timer increments each cycle. Priority is eng_finish, then abort, then timeout:
    - eng_finish: status OK.
    - abort: status ABORT.
    - timer == TIMEOUT-1 with TIMEOUT != 0: status TIMEOUT.
    - Any of these moves the FSM to CLEAR.
  - CLEAR: eng_rst=1 for one cycle; go to REPORT.
  - REPORT: done_valid=1 with done_id and done_status held stable until done_ready. On the handshake go to IDLE.
- Latency:
  - Job accepted in cycle 0 with the block idle: pop in cycle 1, eng_start in cycle 2, RUN from cycle 3.
  - eng_finish first high in cycle k: eng_rst in cycle k+1, done_valid from cycle k+2.
- Boundaries:
  - eng_finish is ignored outside RUN.
  - abort is ignored outside RUN; it is not queued.
  - When finish and timeout coincide, the status is OK.
  - eng_*_base outputs keep the last job's values until the next pop.
  - done_ready is ignored outside REPORT.

Optional Feature:
CONV_SCHED_PERF_EN
- Defined: adds output ports job_cycles[31:0] and jobs_done[15:0].
  - job_cycles holds the RUN cycle count of the last job and is updated in CLEAR.
  - jobs_done increments on each REPORT handshake, saturates at 16'hFFFF, and resets to 0.
- Undefined: neither port nor its logic exists. The rest of the behaviour is identical.

Decomposition:
- Package conv_sched_pkg holds:
  - state encoding: IDLE=0, LAUNCH=1, RUN=2, CLEAR=3, REPORT=4;
  - status codes: ST_OK, ST_TIMEOUT, ST_ABORT;
  - job record field widths/offsets (id, in_base, w_base, out_base packed into one vector).
- One sub-module, conv_job_fifo:
  - parameterised width/depth, synchronous FIFO with async active-low reset;
  - ports: push, pop, din, dout, count, full, empty.
- The FSM, timer and engine interface stay in the top level.

Test Plan:
1. Job id=3, bases 0/3136/4096; engine model raises finish 50 cycles after start -> eng_start in cycle 2, eng_*_base outputs = job, eng_rst 1 cycle, done_valid with id=3, status=00.
2. Push ids 1,2 back-to-back, each engine run 20 cycles -> two eng_start pulses, records id 1 then 2, both OK, busy low only after the second handshake.
3. TIMEOUT=100, engine never finishes -> CLEAR after exactly 100 RUN cycles, status=01, eng_rst pulsed, next job launches normally.
4. DEPTH=4, engine stalled, push 6 jobs -> job_ready drops after 5 accepts (1 popped + 4 queued), 6th held by host, accepted after first completion.
5. Engine finish and abort asserted in the same RUN cycle -> status=00; abort alone at RUN cycle 10 -> status=10.
6. rst=0 at RUN cycle 30 -> all outputs zero immediately, eng_rst=1, FIFO empty, no done_valid after release.
